// File: rtl/axi_spi_pkg.sv
// Shared definitions for the AXI4-Lite SPI register interface: register map,
// field positions, response codes and FSM state encodings.
package axi_spi_pkg;

  // Register word indices (address bits [4:2])
  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_TIMING = 3'd1;
  localparam logic [2:0] IDX_TXDATA = 3'd2;
  localparam logic [2:0] IDX_RXDATA = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;

  localparam int CTRL_START     = 0;
  localparam int CTRL_BUSY      = 1;
  localparam int CTRL_MODE_LSB  = 2;
  localparam int CTRL_MODE_MSB  = 3;
  localparam int CTRL_SPEED_LSB = 4;
  localparam int CTRL_SPEED_MSB = 5;
  localparam int CTRL_LEN_LSB   = 6;
  localparam int CTRL_LEN_MSB   = 7;

  localparam int TIM_IFG_LSB    = 0;
  localparam int TIM_IFG_MSB    = 7;
  localparam int TIM_CSSCK_LSB  = 8;
  localparam int TIM_CSSCK_MSB  = 15;
  localparam int TIM_SCKCS_LSB  = 16;
  localparam int TIM_SCKCS_MSB  = 23;

  localparam int STATUS_DONE    = 0;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wfsm_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rfsm_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_spi_regif.sv
// AXI4-Lite slave register file in front of the SPI register stage: holds SPI
// config and TX word, issues a one-cycle start, captures RX word and DONE.
//
// state  | meaning
// W_IDLE | collecting AW and W independently; commit once both are held
// W_RESP | bvalid asserted, waiting for bready
// R_IDLE | arready high, read data latched on AR handshake
// R_DATA | rvalid asserted, waiting for rready
module axi_lite_spi_regif
  import axi_spi_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                GCLK,
  input  logic                RST_N,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic                start_out,
  input  logic                busy_in,
  output logic [1:0]          spi_mode_out,
  output logic [1:0]          sck_speed_out,
  output logic [1:0]          word_len_out,
  output logic [7:0]          ifg_out,
  output logic [7:0]          cs_sck_out,
  output logic [7:0]          sck_cs_out,
  output logic [31:0]         mosi_data_out,
  input  logic [31:0]         miso_data_in
);

  wfsm_e               wstate_q, wstate_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic [2:0]          aw_idx_q, aw_idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  axi_resp_e           bresp_q, bresp_d;

  rfsm_e               rstate_q, rstate_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  axi_resp_e           rresp_q, rresp_d;
  logic [DATA_W-1:0]   rd_val;
  logic                rd_err;

  logic [1:0]  mode_q, mode_d, speed_q, speed_d, len_q, len_d;
  logic [7:0]  ifg_q, ifg_d, cs_sck_q, cs_sck_d, sck_cs_q, sck_cs_d;
  logic [31:0] txdata_q, txdata_d, rxdata_q, rxdata_d;
  logic        start_q, start_d, pend_q, pend_d, done_q, done_d, busy_prev_q;
  logic        busy_eff;
  logic        unused_addr;

  assign busy_eff    = busy_in | pend_q;
  assign unused_addr = ^{s_awaddr[1:0], s_araddr[1:0]};

  always_comb begin : write_path
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    mode_d    = mode_q;
    speed_d   = speed_q;
    len_d     = len_q;
    ifg_d     = ifg_q;
    cs_sck_d  = cs_sck_q;
    sck_cs_d  = sck_cs_q;
    txdata_d  = txdata_q;
    rxdata_d  = rxdata_q;
    start_d   = 1'b0;
    pend_d    = pend_q;
    done_d    = done_q;

    // pend only bridges the gap until the downstream stage reports busy
    if (busy_in) pend_d = 1'b0;

    case (wstate_q)
      W_IDLE: begin
        if (s_awvalid && !aw_held_q) begin
          aw_held_d = 1'b1;
          aw_idx_d  = s_awaddr[4:2];
        end
        if (s_wvalid && !w_held_q) begin
          w_held_d = 1'b1;
          wdata_d  = s_wdata;
          wstrb_d  = s_wstrb;
        end
        if (aw_held_q && w_held_q) begin
          wstate_d = W_RESP;
          bresp_d  = RESP_OKAY;
          case (aw_idx_q)
            IDX_CTRL: begin
              if (busy_eff) begin
                bresp_d = RESP_SLVERR;
              end else if (wstrb_q[0]) begin
                mode_d  = wdata_q[CTRL_MODE_MSB:CTRL_MODE_LSB];
                speed_d = wdata_q[CTRL_SPEED_MSB:CTRL_SPEED_LSB];
                len_d   = wdata_q[CTRL_LEN_MSB:CTRL_LEN_LSB];
                if (wdata_q[CTRL_START]) begin
                  start_d = 1'b1;
                  pend_d  = 1'b1;
                end
              end
            end
            IDX_TIMING: begin
              if (busy_eff) begin
                bresp_d = RESP_SLVERR;
              end else begin
                if (wstrb_q[0]) ifg_d    = wdata_q[TIM_IFG_MSB:TIM_IFG_LSB];
                if (wstrb_q[1]) cs_sck_d = wdata_q[TIM_CSSCK_MSB:TIM_CSSCK_LSB];
                if (wstrb_q[2]) sck_cs_d = wdata_q[TIM_SCKCS_MSB:TIM_SCKCS_LSB];
              end
            end
            IDX_TXDATA: begin
              if (busy_eff) bresp_d = RESP_SLVERR;
              else          txdata_d = apply_strb(txdata_q, wdata_q, wstrb_q);
            end
            IDX_RXDATA: begin
              bresp_d = RESP_OKAY;
            end
            IDX_STATUS: begin
              if (wstrb_q[0] && wdata_q[STATUS_DONE]) done_d = 1'b0;
            end
            default: bresp_d = RESP_SLVERR;
          endcase
        end
      end
      W_RESP: begin
        if (s_bready) begin
          wstate_d  = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase

    // Completion capture comes last so it beats a same-cycle W1C
    if (busy_prev_q && !busy_in) begin
      rxdata_d = miso_data_in;
      done_d   = 1'b1;
    end
  end

  always_comb begin : read_path
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rd_val   = '0;
    rd_err   = 1'b0;

    case (s_araddr[4:2])
      IDX_CTRL: begin
        rd_val[CTRL_BUSY]                      = busy_eff;
        rd_val[CTRL_MODE_MSB:CTRL_MODE_LSB]    = mode_q;
        rd_val[CTRL_SPEED_MSB:CTRL_SPEED_LSB]  = speed_q;
        rd_val[CTRL_LEN_MSB:CTRL_LEN_LSB]      = len_q;
      end
      IDX_TIMING: begin
        rd_val[TIM_IFG_MSB:TIM_IFG_LSB]        = ifg_q;
        rd_val[TIM_CSSCK_MSB:TIM_CSSCK_LSB]    = cs_sck_q;
        rd_val[TIM_SCKCS_MSB:TIM_SCKCS_LSB]    = sck_cs_q;
      end
      IDX_TXDATA: rd_val = txdata_q;
      IDX_RXDATA: rd_val = rxdata_q;
      IDX_STATUS: rd_val[STATUS_DONE] = done_q;
      default:    rd_err = 1'b1;
    endcase

    case (rstate_q)
      R_IDLE: begin
        if (s_arvalid) begin
          rstate_d = R_DATA;
          rdata_d  = rd_val;
          if (rd_err) rresp_d = RESP_SLVERR;
          else        rresp_d = RESP_OKAY;
        end
      end
      R_DATA: begin
        if (s_rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge GCLK) begin
    if (!RST_N) begin
      wstate_q    <= W_IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      aw_idx_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bresp_q     <= RESP_OKAY;
      rstate_q    <= R_IDLE;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      mode_q      <= '0;
      speed_q     <= '0;
      len_q       <= '0;
      ifg_q       <= '0;
      cs_sck_q    <= '0;
      sck_cs_q    <= '0;
      txdata_q    <= '0;
      rxdata_q    <= '0;
      start_q     <= 1'b0;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_prev_q <= 1'b0;
    end else begin
      wstate_q    <= wstate_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      aw_idx_q    <= aw_idx_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      bresp_q     <= bresp_d;
      rstate_q    <= rstate_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      mode_q      <= mode_d;
      speed_q     <= speed_d;
      len_q       <= len_d;
      ifg_q       <= ifg_d;
      cs_sck_q    <= cs_sck_d;
      sck_cs_q    <= sck_cs_d;
      txdata_q    <= txdata_d;
      rxdata_q    <= rxdata_d;
      start_q     <= start_d;
      pend_q      <= pend_d;
      done_q      <= done_d;
      busy_prev_q <= busy_in;
    end
  end

  assign s_awready     = !aw_held_q;
  assign s_wready      = !w_held_q;
  assign s_bvalid      = (wstate_q == W_RESP);
  assign s_bresp       = bresp_q;
  assign s_arready     = (rstate_q == R_IDLE);
  assign s_rvalid      = (rstate_q == R_DATA);
  assign s_rdata       = rdata_q;
  assign s_rresp       = rresp_q;
  assign start_out     = start_q;
  assign spi_mode_out  = mode_q;
  assign sck_speed_out = speed_q;
  assign word_len_out  = len_q;
  assign ifg_out       = ifg_q;
  assign cs_sck_out    = cs_sck_q;
  assign sck_cs_out    = sck_cs_q;
  assign mosi_data_out = txdata_q;

endmodule

// File: tb/tb_axi_lite_spi_regif.sv
// Directed self-checking bench for axi_lite_spi_regif: register map, start
// pulse, busy/done handling, channel ordering and mid-transfer reset.
module tb_axi_lite_spi_regif;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam int         LIMIT  = 20;

  logic        GCLK = 1'b0;
  logic        RST_N;
  logic [4:0]  s_awaddr, s_araddr;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic        start_out, busy_in;
  logic [1:0]  spi_mode_out, sck_speed_out, word_len_out;
  logic [7:0]  ifg_out, cs_sck_out, sck_cs_out;
  logic [31:0] mosi_data_out, miso_data_in;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  always #5 GCLK = ~GCLK;

  always @(negedge GCLK) if (start_out === 1'b1) start_cnt++;

  axi_lite_spi_regif #(.ADDR_W(5), .DATA_W(32)) dut (
    .GCLK(GCLK), .RST_N(RST_N),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .start_out(start_out), .busy_in(busy_in),
    .spi_mode_out(spi_mode_out), .sck_speed_out(sck_speed_out), .word_len_out(word_len_out),
    .ifg_out(ifg_out), .cs_sck_out(cs_sck_out), .sck_cs_out(sck_cs_out),
    .mosi_data_out(mosi_data_out), .miso_data_in(miso_data_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge GCLK);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the B handshake.
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    logic aw_done, w_done, aw_now, w_now;
    int   n;
    s_awaddr = a; s_awvalid = 1'b1;
    s_wdata  = d; s_wstrb = s; s_wvalid = 1'b1;
    s_bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < LIMIT) begin
      aw_now = s_awready;
      w_now  = s_wready;
      step(1);
      if (aw_now && !aw_done) begin aw_done = 1'b1; s_awvalid = 1'b0; end
      if (w_now && !w_done)   begin w_done  = 1'b1; s_wvalid  = 1'b0; end
      n++;
    end
    chk("wr_addr_data_accept", {31'b0, aw_done && w_done}, 32'd1);
    n = 0;
    while (!s_bvalid && n < LIMIT) begin step(1); n++; end
    chk("wr_bvalid_seen", {31'b0, s_bvalid}, 32'd1);
    resp = s_bresp;
    step(1);
    s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
    n = 0;
    while (!s_arready && n < LIMIT) begin step(1); n++; end
    step(1);
    s_arvalid = 1'b0;
    n = 0;
    while (!s_rvalid && n < LIMIT) begin step(1); n++; end
    chk("rd_rvalid_seen", {31'b0, s_rvalid}, 32'd1);
    d    = s_rdata;
    resp = s_rresp;
    step(1);
    s_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the directed sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr, br;
    int          start_before, bv_cycles;

    RST_N = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    busy_in = 1'b0; miso_data_in = '0;
    step(2);
    RST_N = 1'b1;
    step(1);

    // Reset state
    chk("rst_readies", {29'b0, s_awready, s_wready, s_arready}, 32'h7);
    chk("rst_valids", {30'b0, s_bvalid, s_rvalid}, 32'h0);
    chk("rst_start", {31'b0, start_out}, 32'h0);
    chk("rst_ctrl_fields", {26'b0, word_len_out, sck_speed_out, spi_mode_out}, 32'h0);
    chk("rst_timing_out", {8'b0, sck_cs_out, cs_sck_out, ifg_out}, 32'h0);
    chk("rst_mosi", mosi_data_out, 32'h0);
    for (int i = 0; i < 5; i++) begin
      axi_read(5'(i * 4), rd, rr);
      chk("rst_read_data", rd, 32'h0);
      chk("rst_read_resp", {30'b0, rr}, {30'b0, OKAY});
    end

    // TIMING write and readback
    axi_write(5'h04, 32'h0011_2233, 4'hF, br);
    chk("timing_bresp", {30'b0, br}, {30'b0, OKAY});
    chk("timing_fields", {8'b0, sck_cs_out, cs_sck_out, ifg_out}, 32'h0011_2233);
    axi_read(5'h04, rd, rr);
    chk("timing_readback", rd, 32'h0011_2233);

    // TXDATA, then CTRL with START: mode=1 speed=1 len=3
    axi_write(5'h08, 32'hA5A5_5A5A, 4'hF, br);
    chk("tx_bresp", {30'b0, br}, {30'b0, OKAY});
    chk("tx_mosi", mosi_data_out, 32'hA5A5_5A5A);
    start_before = start_cnt;
    axi_write(5'h00, 32'h0000_00D5, 4'hF, br);
    chk("ctrl_bresp", {30'b0, br}, {30'b0, OKAY});
    chk("ctrl_fields", {26'b0, word_len_out, sck_speed_out, spi_mode_out}, 32'h35);
    chk("start_pulse_len", start_cnt - start_before, 32'd1);
    chk("start_low_after", {31'b0, start_out}, 32'h0);
    axi_read(5'h00, rd, rr);
    chk("ctrl_busy_pending", rd, 32'h0000_00D6);

    // Downstream busy: config writes refused, START ignored
    busy_in = 1'b1;
    step(2);
    axi_write(5'h04, 32'h0000_00FF, 4'hF, br);
    chk("busy_timing_bresp", {30'b0, br}, {30'b0, SLVERR});
    chk("busy_timing_out", {8'b0, sck_cs_out, cs_sck_out, ifg_out}, 32'h0011_2233);
    axi_read(5'h04, rd, rr);
    chk("busy_timing_readback", rd, 32'h0011_2233);
    start_before = start_cnt;
    axi_write(5'h00, 32'h0000_0001, 4'hF, br);
    chk("busy_ctrl_bresp", {30'b0, br}, {30'b0, SLVERR});
    step(2);
    chk("busy_no_start", start_cnt - start_before, 32'd0);
    axi_read(5'h00, rd, rr);
    chk("busy_ctrl_read", rd, 32'h0000_00D6);

    // Completion: busy falls, RX word captured, DONE set then W1C
    miso_data_in = 32'hDEAD_BEEF;
    busy_in = 1'b0;
    step(2);
    axi_read(5'h0C, rd, rr);
    chk("rxdata", rd, 32'hDEAD_BEEF);
    axi_read(5'h10, rd, rr);
    chk("status_done_set", rd, 32'h1);
    axi_read(5'h00, rd, rr);
    chk("ctrl_idle_busy0", rd, 32'h0000_00D4);
    axi_write(5'h10, 32'h1, 4'hF, br);
    chk("status_w1c_bresp", {30'b0, br}, {30'b0, OKAY});
    axi_read(5'h10, rd, rr);
    chk("status_cleared", rd, 32'h0);

    // W leads AW by 3 cycles, bready held low; concurrent unmapped read.
    // 0x30 aliases to 0x10 in a 5-bit address space, so 0x1C stands in.
    s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b0;
    chk("ord_wready_before", {31'b0, s_wready}, 32'h1);
    step(1);
    s_wvalid = 1'b0;
    chk("ord_wready_dropped", {31'b0, s_wready}, 32'h0);
    step(2);
    s_awaddr = 5'h08; s_awvalid = 1'b1;
    s_araddr = 5'h1C; s_arvalid = 1'b1; s_rready = 1'b0;
    step(1);
    s_awvalid = 1'b0; s_arvalid = 1'b0;
    chk("ord_rvalid", {31'b0, s_rvalid}, 32'h1);
    chk("ord_rdata_unmapped", s_rdata, 32'h0);
    chk("ord_rresp_unmapped", {30'b0, s_rresp}, {30'b0, SLVERR});
    s_rready = 1'b1;
    step(1);
    s_rready = 1'b0;
    chk("ord_rvalid_cleared", {31'b0, s_rvalid}, 32'h0);
    bv_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (s_bvalid) bv_cycles++;
      step(1);
    end
    chk("ord_bvalid_held", bv_cycles, 32'd5);
    chk("ord_awready_in_resp", {31'b0, s_awready}, 32'h0);
    chk("ord_bresp", {30'b0, s_bresp}, {30'b0, OKAY});
    s_bready = 1'b1;
    step(1);
    s_bready = 1'b0;
    chk("ord_bvalid_cleared", {31'b0, s_bvalid}, 32'h0);
    chk("ord_single_commit", mosi_data_out, 32'h1234_5678);

    // Byte strobes on TXDATA, unmapped write
    axi_write(5'h08, 32'hFFFF_FFFF, 4'b0101, br);
    axi_read(5'h08, rd, rr);
    chk("wstrb_tx", rd, 32'h12FF_56FF);
    axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, br);
    chk("unmapped_wr_bresp", {30'b0, br}, {30'b0, SLVERR});

    // Reset with both channels mid-transfer
    s_awaddr = 5'h04; s_awvalid = 1'b1; s_wdata = 32'hAB; s_wstrb = 4'hF; s_wvalid = 1'b1;
    s_araddr = 5'h04; s_arvalid = 1'b1; s_bready = 1'b0; s_rready = 1'b0;
    step(1);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    step(2);
    chk("mid_pre_valids", {30'b0, s_bvalid, s_rvalid}, 32'h3);
    RST_N = 1'b0;
    step(1);
    chk("mid_rst_valids", {30'b0, s_bvalid, s_rvalid}, 32'h0);
    chk("mid_rst_ifg", {24'b0, ifg_out}, 32'h0);
    chk("mid_rst_readies", {29'b0, s_awready, s_wready, s_arready}, 32'h7);
    RST_N = 1'b1;
    step(2);
    chk("mid_rst_no_start", {31'b0, start_out}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
